// File: rtl/csr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : csr_pkg
//  Description : Shared types and constants for the CSR UART channel.
//                uart_rx_t is the 1-deep receive holding register that the
//                CSR bank polls. uart_div() gives the rounded baud divisor.
//  Revision    : 1.0  initial release
// ============================================================================
package csr_pkg;

  // Number of bit periods in one 8N1 frame: start + 8 data + stop.
  localparam int UART_FRAME_BITS = 10;

  // Smallest divisor that still leaves room for a mid-bit sample.
  localparam int UART_MIN_DIV = 16;

  typedef struct packed {
    logic       valid;
    logic       overrun;
    logic [7:0] data;
  } uart_rx_t;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int uart_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/csr_if.sv
`default_nettype none
// ============================================================================
//  Module      : csr_if
//  Description : CSR-to-UART signal bundle.
//                MST_UART : CSR bank side (drives write/data/read).
//                SLV_UART : UART peripheral side (drives busy/rx).
//  Signals     : uart_tx_write    1   one-cycle request to send uart_tx_data
//                uart_tx_data     8   byte to transmit
//                uart_rx_read     1   one-cycle acknowledge of uart_rx
//                uart_tx_busy     1   transmitter is sending a frame
//                uart_rx          10  receive holding register
//  Revision    : 1.0  initial release
// ============================================================================
interface csr_if;
  import csr_pkg::*;

  logic       uart_tx_write;
  logic [7:0] uart_tx_data;
  logic       uart_rx_read;
  logic       uart_tx_busy;
  uart_rx_t   uart_rx;

  modport MST_UART (
    output uart_tx_write,
    output uart_tx_data,
    output uart_rx_read,
    input  uart_tx_busy,
    input  uart_rx
  );

  modport SLV_UART (
    input  uart_tx_write,
    input  uart_tx_data,
    input  uart_rx_read,
    output uart_tx_busy,
    output uart_rx
  );

endinterface
`default_nettype wire

// File: rtl/csr_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : csr_uart_rx
//  Description : 8N1 receiver. Two-flop synchroniser, falling-edge start
//                detection, mid-bit sampling timer and receive FSM.
//                Emits a one-cycle pulse on byte_valid_o in the cycle the
//                stop bit is sampled high; byte_data_o is valid with it.
//  Ports       : clk           in   system clock
//                arst_n        in   asynchronous active-low reset
//                rxd_i         in   serial input, asynchronous to clk
//                byte_valid_o  out  good frame received (pulse)
//                byte_data_o   out  received byte
//  Revision    : 1.0  initial release
// ============================================================================
module csr_uart_rx #(
  parameter int DIV = 16
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       rxd_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o
);

  localparam int            TW         = $clog2(DIV);
  localparam logic [TW-1:0] TMR_RELOAD = TW'(DIV - 1);
  localparam logic [TW-1:0] TMR_HALF   = TW'(DIV / 2);

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_WAIT  = 3'd4;   // framing error: wait for line high

  logic [1:0]    sync_q;
  logic          prev_q;
  logic [2:0]    state_q,  state_d;
  logic [TW-1:0] timer_q,  timer_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q,  shift_d;

  logic w_rx;
  logic w_fall;
  logic w_tick;

  assign w_rx   = sync_q[1];
  assign w_fall = prev_q & ~w_rx;
  assign w_tick = (timer_q == '0);

  // State register; synchroniser and edge history reset to the idle line level
  // so that leaving reset never looks like a start bit.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_q   <= 2'b11;
      prev_q   <= 1'b1;
      state_q  <= RX_IDLE;
      timer_q  <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
    end else begin
      sync_q   <= {sync_q[0], rxd_i};
      prev_q   <= w_rx;
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (w_fall) state_d = RX_START;
      RX_START: if (w_tick) state_d = w_rx ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_tick && (bitcnt_q == 3'd7)) state_d = RX_STOP;
      RX_STOP:  if (w_tick) state_d = w_rx ? RX_IDLE : RX_WAIT;
      RX_WAIT:  if (w_rx) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  // Timer, bit counter and shift register. The half-period load in IDLE puts
  // every subsequent sample in the middle of its bit.
  always_comb begin
    timer_d  = timer_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    case (state_q)
      RX_IDLE: begin
        if (w_fall) timer_d = TMR_HALF;
      end
      RX_START: begin
        timer_d = w_tick ? TMR_RELOAD : timer_q - 1'b1;
        if (w_tick) bitcnt_d = '0;
      end
      RX_DATA: begin
        timer_d = w_tick ? TMR_RELOAD : timer_q - 1'b1;
        if (w_tick) begin
          shift_d  = {w_rx, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        timer_d = w_tick ? TMR_RELOAD : timer_q - 1'b1;
      end
      default: begin
        timer_d = timer_q;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    byte_valid_o = (state_q == RX_STOP) && w_tick && w_rx;
  end

  assign byte_data_o = shift_q;

endmodule
`default_nettype wire

// File: rtl/csr_uart.sv
`default_nettype none
// ============================================================================
//  Module      : csr_uart
//  Description : Peripheral end of the CSR UART channel. 8N1, fixed baud.
//                Transmit FSM serialises CPU bytes onto uart_txd; received
//                bytes land in a 1-deep holding register (newest wins,
//                overrun flagged) that the CSR bank polls and acknowledges.
//  Ports       : clk       in   system clock
//                arst_n    in   asynchronous active-low reset
//                csr       SLV  csr_if.SLV_UART (write/data/read in,
//                               busy/rx out)
//                uart_rxd  in   serial input, asynchronous to clk
//                uart_txd  out  serial output, idle high
//  Revision    : 1.0  initial release
// ============================================================================
module csr_uart
  import csr_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic     clk,
  input  logic     arst_n,
  csr_if.SLV_UART  csr,
  input  logic     uart_rxd,
  output logic     uart_txd
);

  localparam int            DIV        = uart_div(CLK_HZ, BAUD);
  localparam int            TW         = $clog2(DIV);
  localparam logic [TW-1:0] TMR_RELOAD = TW'(DIV - 1);

  if (DIV < UART_MIN_DIV) begin : g_div_too_small
    $error("csr_uart: baud divisor %0d is below the minimum of %0d", DIV, UART_MIN_DIV);
  end

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  // --------------------------------------------------------------------------
  // Transmitter
  // --------------------------------------------------------------------------
  logic [1:0]    tx_state_q,  tx_state_d;
  logic [TW-1:0] tx_timer_q,  tx_timer_d;
  logic [2:0]    tx_bitcnt_q, tx_bitcnt_d;
  logic [7:0]    tx_shift_q,  tx_shift_d;
  logic          txd_q,       txd_d;

  logic w_tx_tick;
  logic w_tx_accept;

  assign w_tx_tick   = (tx_timer_q == '0);
  assign w_tx_accept = csr.uart_tx_write && (tx_state_q == TX_IDLE);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tx_state_q  <= TX_IDLE;
      tx_timer_q  <= '0;
      tx_bitcnt_q <= '0;
      tx_shift_q  <= '0;
      txd_q       <= 1'b1;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_timer_q  <= tx_timer_d;
      tx_bitcnt_q <= tx_bitcnt_d;
      tx_shift_q  <= tx_shift_d;
      txd_q       <= txd_d;
    end
  end

  // Next-state logic. Writes outside IDLE never reach the FSM.
  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      TX_IDLE:  if (w_tx_accept) tx_state_d = TX_START;
      TX_START: if (w_tx_tick) tx_state_d = TX_DATA;
      TX_DATA:  if (w_tx_tick && (tx_bitcnt_q == 3'd7)) tx_state_d = TX_STOP;
      TX_STOP:  if (w_tx_tick) tx_state_d = TX_IDLE;
      default:  tx_state_d = TX_IDLE;
    endcase
  end

  // Datapath. The timer sits at the reload value in IDLE so that START is
  // held for a full DIV cycles from the cycle after the write.
  always_comb begin
    tx_timer_d  = tx_timer_q;
    tx_bitcnt_d = tx_bitcnt_q;
    tx_shift_d  = tx_shift_q;
    if (tx_state_q == TX_IDLE) begin
      tx_timer_d  = TMR_RELOAD;
      tx_bitcnt_d = '0;
      if (w_tx_accept) tx_shift_d = csr.uart_tx_data;
    end else begin
      tx_timer_d = w_tx_tick ? TMR_RELOAD : tx_timer_q - 1'b1;
      if ((tx_state_q == TX_DATA) && w_tx_tick) begin
        tx_shift_d  = {1'b0, tx_shift_q[7:1]};
        tx_bitcnt_d = tx_bitcnt_q + 1'b1;
      end
    end
  end

  // Line level is decoded from the next state and registered, so the pin is
  // driven straight from a flop and changes in the same cycle as the state.
  always_comb begin
    case (tx_state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = tx_shift_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  assign uart_txd         = txd_q;
  assign csr.uart_tx_busy = (tx_state_q != TX_IDLE);

  // --------------------------------------------------------------------------
  // Receiver and holding register
  // --------------------------------------------------------------------------
  logic       w_rx_deliver;
  logic [7:0] w_rx_byte;
  uart_rx_t   rx_q, rx_d;

  csr_uart_rx #(
    .DIV (DIV)
  ) u_rx (
    .clk          (clk),
    .arst_n       (arst_n),
    .rxd_i        (uart_rxd),
    .byte_valid_o (w_rx_deliver),
    .byte_data_o  (w_rx_byte)
  );

  // A delivery always wins the data field. Overrun is raised only when an
  // unread byte is overwritten; a read in the same cycle consumes the old one.
  always_comb begin
    rx_d = rx_q;
    if (w_rx_deliver) begin
      rx_d.data    = w_rx_byte;
      rx_d.valid   = 1'b1;
      rx_d.overrun = rx_q.valid && !csr.uart_rx_read;
    end else if (csr.uart_rx_read && rx_q.valid) begin
      rx_d.valid   = 1'b0;
      rx_d.overrun = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_q <= '{valid: 1'b0, overrun: 1'b0, data: 8'h00};
    end else begin
      rx_q <= rx_d;
    end
  end

  assign csr.uart_rx = rx_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_uart.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csr_uart
//  Description : Self-checking bench for csr_uart at DIV=16.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_csr_uart;
  import csr_pkg::*;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int DIV    = 16;                     // (1_600_000 + 50_000) / 100_000
  localparam int FRAME  = UART_FRAME_BITS * DIV;  // cycles per frame

  localparam int OP_FRAME   = 0;
  localparam int OP_READ    = 1;
  localparam int OP_GLITCH  = 2;
  localparam int OP_BADSTOP = 3;

  typedef struct {
    int          op;
    logic [7:0]  data;
    logic [9:0]  exp;   // {valid, overrun, data}
    string       nm;
  } vec_t;

  logic clk = 1'b0;
  logic arst_n;
  logic rxd_drv;
  logic loop_en;
  logic rxd;
  logic txd;

  csr_if u_if ();

  assign rxd = loop_en ? txd : rxd_drv;

  csr_uart #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .csr      (u_if.SLV_UART),
    .uart_rxd (rxd),
    .uart_txd (txd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int deliv_k;

  // Reference model of the holding register.
  logic       m_valid;
  logic       m_ov;
  logic [7:0] m_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one byte and checks the full line waveform and busy timing. A write
  // of poke_data is attempted at cycle poke_at of the frame (-1 for none).
  task automatic tx_frame(input logic [7:0] b, input int poke_at,
                          input logic [7:0] poke_data, input string nm);
    logic [9:0] bits;
    int bad;
    bits = {1'b1, b, 1'b0};
    u_if.uart_tx_data  = b;
    u_if.uart_tx_write = 1'b1;
    step();
    u_if.uart_tx_write = 1'b0;
    bad = 0;
    for (int k = 0; k < FRAME; k++) begin
      if (txd !== bits[k / DIV] || u_if.uart_tx_busy !== 1'b1) bad++;
      if (k == poke_at) begin
        u_if.uart_tx_data  = poke_data;
        u_if.uart_tx_write = 1'b1;
      end
      step();
      u_if.uart_tx_write = 1'b0;
    end
    chk({nm, " frame bad cycles"}, bad, 0);
    chk({nm, " end {txd,busy}"}, {txd, u_if.uart_tx_busy}, 2'b10);
  endtask

  // Drives one frame on rxd_drv followed by one idle bit period. Records the
  // cycle at which valid rises (relative to the start bit) in deliv_k.
  task automatic rx_frame(input logic [7:0] b, input logic stop, input int read_at);
    logic [9:0] bits;
    logic was_valid;
    bits = {stop, b, 1'b0};
    deliv_k = -1;
    for (int k = 0; k < FRAME; k++) begin
      rxd_drv = bits[k / DIV];
      u_if.uart_rx_read = (k == read_at);
      was_valid = u_if.uart_rx.valid;
      step();
      if (deliv_k < 0 && !was_valid && u_if.uart_rx.valid) deliv_k = k + 1;
    end
    u_if.uart_rx_read = 1'b0;
    rxd_drv = 1'b1;
    repeat (DIV) step();
  endtask

  task automatic rx_read();
    u_if.uart_rx_read = 1'b1;
    step();
    u_if.uart_rx_read = 1'b0;
  endtask

  task automatic m_deliver(input logic [7:0] b);
    if (m_valid) m_ov = 1'b1;
    m_valid = 1'b1;
    m_data  = b;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    vec_t vecs[9];
    int   meas;
    int   bad;
    logic [7:0] b;

    vecs[0] = '{OP_FRAME,   8'h5A, {2'b10, 8'h5A}, "rx 5A"};
    vecs[1] = '{OP_READ,    8'h00, {2'b00, 8'h5A}, "read 5A"};
    vecs[2] = '{OP_FRAME,   8'h11, {2'b10, 8'h11}, "rx 11"};
    vecs[3] = '{OP_FRAME,   8'h22, {2'b11, 8'h22}, "rx 22 overrun"};
    vecs[4] = '{OP_READ,    8'h00, {2'b00, 8'h22}, "read clears both"};
    vecs[5] = '{OP_GLITCH,  8'h00, {2'b00, 8'h22}, "glitch"};
    vecs[6] = '{OP_BADSTOP, 8'hFF, {2'b00, 8'h22}, "framing error FF"};
    vecs[7] = '{OP_FRAME,   8'h81, {2'b10, 8'h81}, "rx 81 after error"};
    vecs[8] = '{OP_READ,    8'h00, {2'b00, 8'h81}, "read 81"};

    arst_n = 1'b0;
    rxd_drv = 1'b1;
    loop_en = 1'b0;
    u_if.uart_tx_write = 1'b0;
    u_if.uart_tx_data  = 8'h00;
    u_if.uart_rx_read  = 1'b0;
    meas = -1;
    repeat (3) step();
    chk("reset {txd,busy,rx}", {txd, u_if.uart_tx_busy, u_if.uart_rx}, {1'b1, 1'b0, 10'h000});
    arst_n = 1'b1;
    repeat (4) step();
    chk("idle after reset {txd,busy}", {txd, u_if.uart_tx_busy}, 2'b10);

    // TX: A5 with an ignored write mid-frame, then confirm nothing was queued.
    tx_frame(8'hA5, 50, 8'h3C, "tx A5 with ignored write");
    bad = 0;
    for (int k = 0; k < 2 * DIV; k++) begin
      if (txd !== 1'b1 || u_if.uart_tx_busy !== 1'b0) bad++;
      step();
    end
    chk("no queued frame after ignored write", bad, 0);

    // Back-to-back: second write on the first cycle busy is low.
    tx_frame(8'hA5, -1, 8'h00, "tx A5");
    tx_frame(8'h3C, -1, 8'h00, "tx 3C back-to-back");
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(0, 255));
      tx_frame(b, -1, 8'h00, "tx random");
    end
    repeat (DIV) step();

    // RX table.
    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_FRAME: begin
          rx_frame(vecs[i].data, 1'b1, -1);
          if (i == 0) meas = deliv_k;
        end
        OP_READ:    rx_read();
        OP_GLITCH: begin
          rxd_drv = 1'b0;
          repeat (4) step();
          rxd_drv = 1'b1;
          repeat (2 * DIV) step();
        end
        default:    rx_frame(vecs[i].data, 1'b0, -1);
      endcase
      chk(vecs[i].nm, u_if.uart_rx, vecs[i].exp);
    end

    // Delivery must land inside the stop bit, after its mid-point sample.
    chk("rx delivery inside stop bit",
        (meas >= 9 * DIV + DIV / 2) && (meas < FRAME), 1);

    // Read and delivery in the same cycle: newest byte, no overrun.
    rx_frame(8'h33, 1'b1, -1);
    chk("rx 33", u_if.uart_rx, {2'b10, 8'h33});
    rx_frame(8'h44, 1'b1, (meas > 0) ? meas - 1 : -2);
    chk("read with delivery", u_if.uart_rx, {2'b10, 8'h44});
    rx_read();

    // Randomised RX against the holding-register model.
    m_valid = 1'b0;
    m_ov    = 1'b0;
    m_data  = 8'h44;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        rx_read();
        if (m_valid) begin
          m_valid = 1'b0;
          m_ov    = 1'b0;
        end
      end
      b = 8'($urandom_range(0, 255));
      rx_frame(b, 1'b1, -1);
      m_deliver(b);
      chk("rx random vs model", u_if.uart_rx, {m_valid, m_ov, m_data});
    end
    rx_read();

    // Loopback with reset pulsed mid-frame.
    loop_en = 1'b1;
    u_if.uart_tx_data  = 8'h55;
    u_if.uart_tx_write = 1'b1;
    step();
    u_if.uart_tx_write = 1'b0;
    repeat (3 * DIV + 5) step();
    arst_n = 1'b0;
    #1;
    chk("reset mid-frame {txd,busy,valid}",
        {txd, u_if.uart_tx_busy, u_if.uart_rx.valid}, 3'b100);
    step();
    arst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < FRAME + DIV; k++) begin
      if (txd !== 1'b1 || u_if.uart_rx.valid !== 1'b0) bad++;
      step();
    end
    chk("no partial byte after reset", bad, 0);
    tx_frame(8'h0F, -1, 8'h00, "loopback tx 0F");
    repeat (DIV) step();
    chk("loopback rx 0F", u_if.uart_rx, {2'b10, 8'h0F});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
